// File: rtl/pipe_stage_elastic_pkg.sv
// Shared payload layout and defaults for the elastic pipeline stage registers.
// Each stage instantiation sizes its payload from STAGE_DATA_W.
package pipe_stage_elastic_pkg;

    localparam int PC_W          = 32;
    localparam int REG_IDX_W     = 5;
    localparam int IMM_W         = 16;
    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [0:0] {
        OP_ALU = 1'b0,
        OP_MEM = 1'b1
    } ctrl_op_e;

    typedef struct packed {
        logic [PC_W-1:0]      pc_4;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [IMM_W-1:0]     imm16;
        ctrl_op_e             op;
    } stage_payload_t;

    localparam int STAGE_DATA_W = $bits(stage_payload_t);

    // Beats held by a stage, from its main and skid valid bits.
    function automatic logic [1:0] beat_count(input logic m_valid, input logic s_valid);
        return {1'b0, m_valid} + {1'b0, s_valid};
    endfunction

endpackage

// File: rtl/stage_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module stage_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage register with optional two-entry skid buffer,
// flush, occupancy reporting and a saturating backpressure counter.
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int DATA_W = STAGE_DATA_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stat_clr
);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              s_valid;
    logic              accept;

    // A beat offered during flush is dropped even when in_ready is high.
    assign accept = in_valid && in_ready && !flush;

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] s_data;

            assign in_ready = !s_valid;

            // NOTE: the payload registers are reset as well, so out_data reads 0
            // after reset or flush instead of a stale or unknown word.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_valid <= 1'b0;
                    m_data  <= '0;
                    s_valid <= 1'b0;
                    s_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    m_data  <= '0;
                    s_valid <= 1'b0;
                    s_data  <= '0;
                end else if (s_valid) begin
                    // in_ready is low here, so only the skid-to-main move can happen.
                    if (out_ready) begin
                        m_data  <= s_data;
                        s_valid <= 1'b0;
                    end
                end else if (accept) begin
                    if (!m_valid || out_ready) begin
                        m_valid <= 1'b1;
                        m_data  <= in_data;
                    end else begin
                        s_valid <= 1'b1;
                        s_data  <= in_data;
                    end
                end else if (out_ready) begin
                    m_valid <= 1'b0;
                end
            end
        end else begin : g_single
            assign in_ready = !m_valid || out_ready;
            assign s_valid  = 1'b0;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_valid <= 1'b0;
                    m_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    m_data  <= '0;
                end else if (accept) begin
                    m_valid <= 1'b1;
                    m_data  <= in_data;
                end else if (out_ready) begin
                    m_valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign occupancy = beat_count(m_valid, s_valid);

    stage_sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (stat_clr),
        .inc  (m_valid && !out_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench: three stage variants (skid/16-bit count, skid/3-bit count,
// single register) share one stimulus stream and are compared against a FIFO model.
module tb_pipe_stage_elastic;
    import pipe_stage_elastic_pkg::*;

    localparam int DW   = STAGE_DATA_W;
    localparam int NDUT = 3;
    localparam int CAP  [NDUT] = '{2, 2, 1};
    localparam int SMAX [NDUT] = '{65535, 7, 65535};

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, out_ready, stat_clr;
    logic [DW-1:0] in_data;
    logic          rdy [NDUT];
    logic          vld [NDUT];
    logic [DW-1:0] od  [NDUT];
    logic [1:0]    occ [NDUT];
    logic [15:0]   sc0, sc2;
    logic [2:0]    sc1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each stage is a bounded FIFO plus an integer stall count.
    int            m_cnt   [NDUT];
    logic [DW-1:0] m_buf   [NDUT][2];
    int            m_stall [NDUT];
    bit            m_zero  [NDUT];

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(DW), .SKID(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(in_data), .out_valid(vld[0]), .out_ready(out_ready), .out_data(od[0]),
        .occupancy(occ[0]), .stall_cnt(sc0), .stat_clr(stat_clr));

    pipe_stage_elastic #(.DATA_W(DW), .SKID(1), .CNT_W(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(in_data), .out_valid(vld[1]), .out_ready(out_ready), .out_data(od[1]),
        .occupancy(occ[1]), .stall_cnt(sc1), .stat_clr(stat_clr));

    pipe_stage_elastic #(.DATA_W(DW), .SKID(0), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_data(in_data), .out_valid(vld[2]), .out_ready(out_ready), .out_data(od[2]),
        .occupancy(occ[2]), .stall_cnt(sc2), .stat_clr(stat_clr));

    function automatic logic [15:0] stall_of(input int k);
        if (k == 0) return sc0;
        if (k == 1) return {13'b0, sc1};
        return sc2;
    endfunction

    function automatic bit exp_ready(input int k);
        if (CAP[k] == 2) return m_cnt[k] < 2;
        return (m_cnt[k] == 0) || out_ready;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_cnt[k]   = 0;
            m_stall[k] = 0;
            m_zero[k]  = 1'b1;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < NDUT; k++) begin
            bit pop, push;
            pop  = (m_cnt[k] > 0) && out_ready;
            push = in_valid && exp_ready(k) && !flush;
            if (stat_clr) m_stall[k] = 0;
            else if (m_cnt[k] > 0 && !out_ready && m_stall[k] < SMAX[k]) m_stall[k]++;
            if (pop) begin
                m_buf[k][0] = m_buf[k][1];
                m_cnt[k]--;
            end
            if (flush) begin
                m_cnt[k]  = 0;
                m_zero[k] = 1'b1;
            end else if (push) begin
                m_buf[k][m_cnt[k]] = in_data;
                m_cnt[k]++;
                m_zero[k] = 1'b0;
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stat_clr = 1'b0;
        in_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (vld[k] !== 1'b0 || occ[k] !== 2'd0 || stall_of(k) !== 16'd0 || od[k] !== '0) begin
                n_errors++;
                $display("FAIL reset_state dut%0d: valid=%b occ=%0d stall=%0d data=%h, want 0/0/0/0",
                         k, vld[k], occ[k], stall_of(k), od[k]);
            end
        end
        rst_n = 1'b1;
        step();
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (rdy[k] !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_in_ready dut%0d: got %b want 1", k, rdy[k]);
            end
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i + 1);
            #1;
            n_checks++;
            if (rdy[0] !== 1'b1) begin
                n_errors++;
                $display("FAIL stream_in_ready beat%0d: got %b want 1", i, rdy[0]);
            end
            step();
            n_checks++;
            if (vld[0] !== 1'b1 || od[0] !== DW'(i + 1) || occ[0] !== 2'd1 || sc0 !== 16'd0) begin
                n_errors++;
                $display("FAIL stream_out beat%0d: valid=%b data=%0d occ=%0d stall=%0d, want 1/%0d/1/0",
                         i, vld[0], od[0], occ[0], sc0, i + 1);
            end
        end
        in_valid = 1'b0;
        #1;
        step();
        n_checks++;
        if (vld[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL stream_drain: valid=%b want 0", vld[0]);
        end
    endtask

    task automatic test_backpressure();
        int held;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'('hA5);
        #1; step();
        in_data = DW'('hB6);
        #1; step();
        in_valid = 1'b0;
        #1;
        held = 1;
        n_checks++;
        if (occ[0] !== 2'd2 || rdy[0] !== 1'b0 || vld[0] !== 1'b1 || od[0] !== DW'('hA5)) begin
            n_errors++;
            $display("FAIL bp_full: occ=%0d in_ready=%b valid=%b data=%h, want 2/0/1/a5",
                     occ[0], rdy[0], vld[0], od[0]);
        end
        repeat (3) begin
            step();
            held++;
            n_checks++;
            if (od[0] !== DW'('hA5) || vld[0] !== 1'b1 || sc0 !== 16'(held)) begin
                n_errors++;
                $display("FAIL bp_hold: data=%h valid=%b stall=%0d, want a5/1/%0d", od[0], vld[0], sc0, held);
            end
        end
        out_ready = 1'b1;
        #1;
        step();
        n_checks++;
        if (vld[0] !== 1'b1 || od[0] !== DW'('hB6) || occ[0] !== 2'd1) begin
            n_errors++;
            $display("FAIL bp_second: valid=%b data=%h occ=%0d, want 1/b6/1", vld[0], od[0], occ[0]);
        end
        step();
        n_checks++;
        if (vld[0] !== 1'b0 || occ[0] !== 2'd0 || sc0 !== 16'(held)) begin
            n_errors++;
            $display("FAIL bp_empty: valid=%b occ=%0d stall=%0d, want 0/0/%0d", vld[0], occ[0], sc0, held);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'('hC1);
        #1; step();
        in_data = DW'('hC2);
        #1; step();
        n_checks++;
        if (occ[0] !== 2'd2) begin
            n_errors++;
            $display("FAIL flush_prefill: occ=%0d want 2", occ[0]);
        end
        flush   = 1'b1;
        in_data = DW'('hFF);
        #1; step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (vld[k] !== 1'b0 || occ[k] !== 2'd0 || rdy[k] !== 1'b1 || od[k] !== '0 ||
                stall_of(k) !== 16'(m_stall[k])) begin
                n_errors++;
                $display("FAIL flush_state dut%0d: valid=%b occ=%0d in_ready=%b data=%h stall=%0d, want 0/0/1/0/%0d",
                         k, vld[k], occ[k], rdy[k], od[k], stall_of(k), m_stall[k]);
            end
        end
        // Flush with an empty stage and in_ready high must still drop the offered beat.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        flush     = 1'b1;
        in_data   = DW'('hEE);
        #1; step();
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (2) begin
            #1;
            for (int k = 0; k < NDUT; k++) begin
                n_checks++;
                if (vld[k] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL flush_dropped dut%0d: valid=%b data=%h, want no beat", k, vld[k], od[k]);
                end
            end
            step();
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'('h77);
        stat_clr  = 1'b1;
        #1; step();
        in_valid = 1'b0;
        stat_clr = 1'b0;
        #1;
        n_checks++;
        if (sc1 !== 3'd0 || vld[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_start: stall=%0d valid=%b, want 0/1", sc1, vld[1]);
        end
        for (int i = 1; i <= 10; i++) begin
            step();
            n_checks++;
            if (sc1 !== 3'((i < 7) ? i : 7)) begin
                n_errors++;
                $display("FAIL sat_count cycle%0d: got %0d want %0d", i, sc1, (i < 7) ? i : 7);
            end
        end
        n_checks++;
        if (sc0 !== 16'd10) begin
            n_errors++;
            $display("FAIL sat_wide: got %0d want 10", sc0);
        end
        stat_clr = 1'b1;
        #1; step();
        stat_clr = 1'b0;
        #1;
        n_checks++;
        if (sc1 !== 3'd0 || sc0 !== 16'd0) begin
            n_errors++;
            $display("FAIL sat_clear: narrow=%0d wide=%0d, want 0/0", sc1, sc0);
        end
        step();
        n_checks++;
        if (sc1 !== 3'd1 || sc0 !== 16'd1) begin
            n_errors++;
            $display("FAIL sat_after_clear: narrow=%0d wide=%0d, want 1/1", sc1, sc0);
        end
        out_ready = 1'b1;
        #1; step(); step();
    endtask

    task automatic test_skid0();
        int next_in  = 1;
        int next_out = 1;
        in_valid = 1'b1;
        in_data  = DW'(next_in);
        for (int c = 0; c < 12; c++) begin
            bit took;
            out_ready = (c % 3) != 1;
            #1;
            n_checks++;
            if (rdy[2] !== exp_ready(2) || occ[2] > 2'd1) begin
                n_errors++;
                $display("FAIL skid0_ready cycle%0d: in_ready=%b occ=%0d, want %b/<=1",
                         c, rdy[2], occ[2], exp_ready(2));
            end
            if (vld[2] === 1'b1 && out_ready) begin
                n_checks++;
                if (od[2] !== DW'(next_out)) begin
                    n_errors++;
                    $display("FAIL skid0_order: got %0d want %0d", od[2], next_out);
                end
                next_out++;
            end
            took = (rdy[2] === 1'b1);
            step();
            if (took) begin
                next_in++;
                in_data = DW'(next_in);
            end
        end
        n_checks++;
        if (next_out < 6) begin
            n_errors++;
            $display("FAIL skid0_throughput: delivered %0d want >=5", next_out - 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1; step(); step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            in_data   = {$urandom, $urandom};
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 19) == 0;
            stat_clr  = $urandom_range(0, 29) == 0;
            #1;
            for (int k = 0; k < NDUT; k++) begin
                n_checks++;
                if (vld[k] !== (m_cnt[k] > 0) || occ[k] !== 2'(m_cnt[k]) || rdy[k] !== exp_ready(k) ||
                    stall_of(k) !== 16'(m_stall[k]) ||
                    ((m_cnt[k] > 0) && od[k] !== m_buf[k][0]) || (m_zero[k] && od[k] !== '0)) begin
                    n_errors++;
                    $display("FAIL random dut%0d cycle%0d: valid=%b occ=%0d rdy=%b stall=%0d data=%h, want %b/%0d/%b/%0d/%h",
                             k, c, vld[k], occ[k], rdy[k], stall_of(k), od[k], m_cnt[k] > 0, m_cnt[k],
                             exp_ready(k), m_stall[k], (m_cnt[k] > 0) ? m_buf[k][0] : '0);
                end
            end
            step();
        end
        in_valid = 1'b0; flush = 1'b0; stat_clr = 1'b0; out_ready = 1'b1;
        #1; step(); step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'('hD1);
        #1; step();
        in_data = DW'('hD2);
        #1; step();
        in_valid = 1'b0;
        #1; step();
        n_checks++;
        if (occ[0] !== 2'd2 || sc0 !== 16'(m_stall[0]) || sc0 === 16'd0) begin
            n_errors++;
            $display("FAIL areset_prefill: occ=%0d stall=%0d, want 2/%0d", occ[0], sc0, m_stall[0]);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (vld[k] !== 1'b0 || occ[k] !== 2'd0 || stall_of(k) !== 16'd0) begin
                n_errors++;
                $display("FAIL areset_immediate dut%0d: valid=%b occ=%0d stall=%0d, want 0/0/0",
                         k, vld[k], occ[k], stall_of(k));
            end
        end
        #3;
        rst_n = 1'b1;
        step();
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (rdy[k] !== 1'b1 || vld[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL areset_release dut%0d: in_ready=%b valid=%b, want 1/0", k, rdy[k], vld[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturation();
        test_skid0();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
